// File: rtl/sysram_arb.sv
// Two-requester round-robin arbiter in front of a single-port system RAM.
// Grant and RAM controls are combinational; read responses return one cycle after the grant.
module sysram_arb #(
    parameter int BYTE     = 0,
    parameter int BYTE_CNT = 0,
    parameter int WORD     = 0,
    parameter int ADDRW    = 0
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_valid,
    output logic                m0_ready,
    input  logic [ADDRW-1:0]    m0_addr,
    input  logic [BYTE_CNT-1:0] m0_we,
    input  logic [WORD-1:0]     m0_wdata,
    output logic [WORD-1:0]     m0_rdata,
    output logic                m0_rvalid,

    input  logic                m1_valid,
    output logic                m1_ready,
    input  logic [ADDRW-1:0]    m1_addr,
    input  logic [BYTE_CNT-1:0] m1_we,
    input  logic [WORD-1:0]     m1_wdata,
    output logic [WORD-1:0]     m1_rdata,
    output logic                m1_rvalid,

    output logic [BYTE_CNT-1:0] ram_we,
    output logic                ram_re,
    output logic [ADDRW-1:0]    ram_addr,
    output logic [WORD-1:0]     ram_din,
    input  logic [WORD-1:0]     ram_dout
);

    logic last_q, last_d;
    logic rd_pend0_q, rd_pend0_d;
    logic rd_pend1_q, rd_pend1_d;
    logic gnt0, gnt1;
    logic rd0, rd1;

    // On contention the requester that did not win last time is served.
    always_comb begin
        gnt0 = rst_n && m0_valid && (!m1_valid || last_q);
        gnt1 = rst_n && m1_valid && (!m0_valid || !last_q);
        rd0  = gnt0 && (m0_we == '0);
        rd1  = gnt1 && (m1_we == '0);
    end

    always_comb begin
        ram_we   = '0;
        ram_re   = 1'b0;
        ram_addr = m0_addr;
        ram_din  = m0_wdata;
        if (gnt0) begin
            ram_we = m0_we;
            ram_re = rd0;
        end else if (gnt1) begin
            ram_we   = m1_we;
            ram_re   = rd1;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    always_comb begin
        last_d     = last_q;
        if (gnt0) last_d = 1'b0;
        if (gnt1) last_d = 1'b1;
        rd_pend0_d = rd0;
        rd_pend1_d = rd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            rd_pend0_q <= rd_pend0_d;
            rd_pend1_q <= rd_pend1_d;
        end
    end

    // A response due in a reset cycle is dropped.
    assign m0_ready  = gnt0;
    assign m1_ready  = gnt1;
    assign m0_rvalid = rst_n && rd_pend0_q;
    assign m1_rvalid = rst_n && rd_pend1_q;
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_sysram_arb.sv
// Scoreboard bench for sysram_arb: driver predicts grants and read data from a
// word-array reference; a separate monitor checks every read response.
module tb_sysram_arb;

    localparam int BYTE = 8, BYTE_CNT = 4, WORD = 32, ADDRW = 8;

    logic clk, rst_n;
    logic m0_valid, m0_ready, m0_rvalid, m1_valid, m1_ready, m1_rvalid;
    logic [ADDRW-1:0] m0_addr, m1_addr, ram_addr;
    logic [BYTE_CNT-1:0] m0_we, m1_we, ram_we;
    logic [WORD-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_din, ram_dout;
    logic ram_re;

    sysram_arb #(.BYTE(BYTE), .BYTE_CNT(BYTE_CNT), .WORD(WORD), .ADDRW(ADDRW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_we(m0_we),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_we(m1_we),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM attached to the DUT; registered read port.
    logic [WORD-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_re) ram_dout <= mem[ram_addr];
        for (int b = 0; b < BYTE_CNT; b++)
            if (ram_we[b]) mem[ram_addr][b*BYTE +: BYTE] = ram_din[b*BYTE +: BYTE];
    end

    typedef struct {
        int              req;
        logic [WORD-1:0] data;
        int              due;
    } exp_t;

    exp_t            sbq[$];
    logic [WORD-1:0] ref_mem [256];
    int              last_m;
    int              cyc;
    int              errors, checks;
    int              dut_g0, dut_g1, idle_cnt;

    task automatic chk(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: arbitration and memory contents derived from the request stream.
    task automatic step(output int g);
        logic [BYTE_CNT-1:0] ewe;
        #1;
        g = -1;
        if (rst_n) begin
            if (m0_valid && m1_valid) g = (last_m == 1) ? 0 : 1;
            else if (m0_valid)        g = 0;
            else if (m1_valid)        g = 1;
        end
        ewe = (g == 0) ? m0_we : (g == 1) ? m1_we : '0;
        chk("m0_ready", m0_ready, (g == 0));
        chk("m1_ready", m1_ready, (g == 1));
        chk("ram_we", ram_we, ewe);
        chk("ram_re", ram_re, (g >= 0) && (ewe == 0));
        if (g >= 0) begin
            chk("ram_addr", ram_addr, (g == 0) ? m0_addr : m1_addr);
            chk("ram_din", ram_din, (g == 0) ? m0_wdata : m1_wdata);
        end
        if (m0_ready) dut_g0++;
        if (m1_ready) dut_g1++;
        if (!m0_ready && !m1_ready) idle_cnt++;
        if (!rst_n) begin
            last_m = 1;
            sbq.delete();
        end else if (g >= 0) begin
            logic [ADDRW-1:0]    a;
            logic [WORD-1:0]     d;
            a = (g == 0) ? m0_addr : m1_addr;
            d = (g == 0) ? m0_wdata : m1_wdata;
            last_m = g;
            if (ewe == 0) sbq.push_back('{req: g, data: ref_mem[a], due: cyc + 1});
            else
                for (int b = 0; b < BYTE_CNT; b++)
                    if (ewe[b]) ref_mem[a][b*BYTE +: BYTE] = d[b*BYTE +: BYTE];
        end
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [ADDRW-1:0] a, input logic [BYTE_CNT-1:0] we, input logic [WORD-1:0] d);
        m0_valid = v; m0_addr = a; m0_we = we; m0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic [ADDRW-1:0] a, input logic [BYTE_CNT-1:0] we, input logic [WORD-1:0] d);
        m1_valid = v; m1_addr = a; m1_we = we; m1_wdata = d;
    endtask

    // Monitor: every cycle, compare read responses against the scoreboard head.
    initial begin
        exp_t e;
        bit   has;
        forever begin
            @(negedge clk);
            cyc++;
            #2;
            has = 0;
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL rvalid_missing req %0d: got none expected data 0x%0h", e.req, e.data);
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e   = sbq.pop_front();
                has = 1;
            end
            chk("m0_rvalid", m0_rvalid, has && e.req == 0);
            chk("m1_rvalid", m1_rvalid, has && e.req == 1);
            if (has) chk("rdata", (e.req == 0) ? m0_rdata : m1_rdata, e.data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        logic rv0, rv1;
        errors = 0; checks = 0; cyc = 0; last_m = 1;
        dut_g0 = 0; dut_g1 = 0; idle_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h9E37_79B1 * (i + 1);
            ref_mem[i] = 32'h9E37_79B1 * (i + 1);
        end
        rst_n = 1'b0;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        @(negedge clk);

        // Reset with requests present: nothing may be granted.
        set0(1, 8'h33, 4'h0, 0);
        set1(1, 8'h34, 4'hF, 32'h1);
        step(g); step(g);
        rst_n = 1'b1;

        // Contention reads: m0 first, then m1, responses one cycle later each.
        set0(1, 8'h10, 4'h0, 0); set1(1, 8'h20, 4'h0, 0);
        step(g);
        chk("first_contention_m0", g, 0);
        set0(0, 0, 0, 0);
        step(g);
        set1(0, 0, 0, 0);
        step(g); step(g);

        // Full write then read-after-write.
        set0(1, 8'h05, 4'hF, 32'hDEAD_BEEF); step(g);
        set0(1, 8'h05, 4'h0, 0);            step(g);
        set0(0, 0, 0, 0);                    step(g);

        // Byte lane write into a known word.
        set0(1, 8'h07, 4'hF, 32'h1122_3344); step(g);
        set0(1, 8'h07, 4'b0010, 32'h0000_AB00); step(g);
        set0(1, 8'h07, 4'h0, 0); step(g);
        set0(0, 0, 0, 0); step(g); step(g);
        chk("byte_merge_ref", ref_mem[7], 32'h1122_AB44);

        // Both continuously valid for 8 cycles.
        dut_g0 = 0; dut_g1 = 0; idle_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            set0(1, 8'(i), 4'h0, 0);
            set1(1, 8'(i + 64), 4'h0, 0);
            step(g);
        end
        chk("alt_g0", dut_g0, 4);
        chk("alt_g1", dut_g1, 4);
        chk("alt_idle", idle_cnt, 0);
        set0(0, 0, 0, 0); set1(0, 0, 0, 0); step(g);

        // Only m1 for 3 cycles; m0 then wins the next contention.
        dut_g1 = 0;
        for (int i = 0; i < 3; i++) begin
            set1(1, 8'(i + 100), 4'h0, 0);
            step(g);
        end
        chk("m1_only_grants", dut_g1, 3);
        set0(1, 8'h11, 4'h0, 0); set1(1, 8'h12, 4'h0, 0);
        step(g);
        chk("after_m1_only", g, 0);
        set0(0, 0, 0, 0); set1(0, 0, 0, 0); step(g);

        // Reset right after a read grant drops the response.
        set1(1, 8'h40, 4'h0, 0); step(g);
        set1(0, 0, 0, 0);
        rst_n = 1'b0;
        set0(1, 8'h41, 4'h0, 0); set1(1, 8'h42, 4'h0, 0);
        step(g);
        rst_n = 1'b1;
        step(g);
        chk("post_reset_m0", g, 0);
        set0(0, 0, 0, 0); set1(0, 0, 0, 0); step(g);

        // Random traffic; an unaccepted request is held stable.
        for (int i = 0; i < 400; i++) begin
            rv0 = m0_valid && !(g == 0);
            rv1 = m1_valid && !(g == 1);
            if (!(m0_valid && g != 0))
                set0($urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)),
                     ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15)), $urandom);
            if (!(m1_valid && g != 1))
                set1($urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)),
                     ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15)), $urandom);
            rst_n = ($urandom_range(0, 49) != 0);
            if (rv0 && !m0_valid) set0(1, m0_addr, m0_we, m0_wdata);
            if (rv1 && !m1_valid) set1(1, m1_addr, m1_we, m1_wdata);
            step(g);
        end
        rst_n = 1'b1;
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        step(g); step(g);
        #3;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
